// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply / restoring divide sequencer that borrows the
// shared add/sub unit while busy and passes the normal ALU operands through when idle.
module alu_muldiv_seq #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   DIV0_QUOT = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div0,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic             alu_sub,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_sub,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;      // MUL partial product high half, DIV partial remainder
    logic [WIDTH-1:0] q;        // MUL multiplier/product low half, DIV dividend/quotient
    logic [WIDTH-1:0] b_r;
    logic             op_r;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             div_zero;

    assign busy     = (state != IDLE);
    assign done     = (state == FIN);
    assign div_zero = op_r & (b_r == '0);

    // Add/sub unit operand mux: pass-through when idle, sequencer-owned otherwise
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        case (state)
            IDLE: begin
                add_a   = alu_a;
                add_b   = alu_b;
                add_sub = alu_sub;
            end
            RUN: begin
                add_a   = op_r ? {acc[WIDTH-2:0], q[WIDTH-1]} : acc;
                add_b   = b_r;
                add_sub = op_r;
            end
            default: begin
                add_a   = '0;
                add_b   = '0;
                add_sub = 1'b0;
            end
        endcase
    end

    // One shift-add (MUL) or restoring-subtract (DIV) step using the add/sub result
    always_comb begin
        acc_nxt = acc;
        q_nxt   = q;
        if (op_r == 1'b0) begin
            if (q[0]) begin
                {acc_nxt, q_nxt} = {add_cout, add_sum, q[WIDTH-1:1]};
            end else begin
                {acc_nxt, q_nxt} = {1'b0, acc, q[WIDTH-1:1]};
            end
        end else begin
            // A set remainder MSB means the shifted value already exceeds the divisor
            if (acc[WIDTH-1] | add_cout) begin
                acc_nxt = add_sum;
                q_nxt   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = {acc[WIDTH-2:0], q[WIDTH-1]};
                q_nxt   = {q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sequencer FSM, datapath registers and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            b_r    <= '0;
            op_r   <= 1'b0;
            res_hi <= '0;
            res_lo <= '0;
            div0   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        b_r   <= opb;
                        cnt   <= '0;
                        acc   <= '0;
                        q     <= opa;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    q   <= q_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state <= FIN;
                        // With a zero divisor the remainder path shifts the dividend out unchanged
                        res_hi <= acc_nxt;
                        res_lo <= div_zero ? DIV0_QUOT : q_nxt;
                        div0   <= div_zero;
                    end else begin
                        state <= RUN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized and directed bench for alu_muldiv_seq; the add/sub unit and the
// arithmetic reference are modelled here with plain operators.
module tb_alu_muldiv_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [7:0] opa = 8'd0;
    logic [7:0] opb = 8'd0;
    logic       busy;
    logic       done;
    logic [7:0] res_hi;
    logic [7:0] res_lo;
    logic       div0;
    logic [7:0] alu_a = 8'd0;
    logic [7:0] alu_b = 8'd0;
    logic       alu_sub = 1'b0;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_sub;
    logic [7:0] add_sum;
    logic       add_cout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b ^ {8{add_sub}}} + {8'd0, add_sub};

    alu_muldiv_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo), .div0(div0),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub),
        .add_a(add_a), .add_b(add_b), .add_sub(add_sub),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result from plain arithmetic: {hi, lo, div0}
    function automatic logic [16:0] ref_result(input logic o, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        if (o == 1'b0) begin
            p = 16'(a) * 16'(b);
            return {p, 1'b0};
        end else if (b == 8'd0) begin
            return {a, 8'hFF, 1'b1};
        end else begin
            return {a % b, a / b, 1'b0};
        end
    endfunction

    // Runs one op; optionally pulses start (with other operands) in RUN and FIN
    task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b, input bit inject);
        logic [16:0] exp;
        int n;
        bit got;
        exp = ref_result(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; opa = ~a; opb = b + 8'd1;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            if (n == 3) begin
                alu_a = 8'($urandom); alu_b = ~b; alu_sub = ~o;
                if (inject) start = 1'b1;
                #1;
                chk("run_add_b", {8'd0, add_b}, {8'd0, b});
                chk("run_add_sub", {15'd0, add_sub}, {15'd0, o});
                chk("run_busy", {15'd0, busy}, 16'd1);
            end
            if (n == 4) start = 1'b0;
            @(posedge clk); #1;
            n++;
            if (done) got = 1'b1;
        end
        chk("latency", 16'(n), 16'd8);
        chk("res", {res_hi, res_lo}, exp[16:1]);
        chk("div0", {15'd0, div0}, {15'd0, exp[0]});
        chk("fin_busy", {15'd0, busy}, 16'd1);
        chk("fin_add", {add_a, add_b}, 16'd0);
        chk("fin_add_sub", {15'd0, add_sub}, 16'd0);
        if (inject) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle_done", {14'd0, busy, done}, 16'd0);
        chk("res_held", {res_hi, res_lo}, exp[16:1]);
        if (inject) begin
            @(posedge clk); #1;
            chk("ignored_start_busy", {15'd0, busy}, 16'd0);
        end
    endtask

    initial begin
        #1;
        chk("rst_state", {11'd0, busy, done, div0, 2'b00}, 16'd0);
        chk("rst_res", {res_hi, res_lo}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        alu_a = 8'h10; alu_b = 8'h03; alu_sub = 1'b1;
        #1;
        chk("pass_ab", {add_a, add_b}, 16'h1003);
        chk("pass_sub", {15'd0, add_sub}, 16'd1);

        run_op(1'b0, 8'h0D, 8'h0B, 1'b0);
        run_op(1'b0, 8'hFF, 8'hFF, 1'b0);
        run_op(1'b0, 8'h00, 8'h7C, 1'b0);
        run_op(1'b1, 8'hC8, 8'h07, 1'b0);
        run_op(1'b1, 8'hFF, 8'h01, 1'b0);
        run_op(1'b1, 8'h05, 8'h09, 1'b0);
        run_op(1'b1, 8'h5A, 8'h00, 1'b0);
        run_op(1'b0, 8'h12, 8'h34, 1'b0);
        run_op(1'b1, 8'h81, 8'h80, 1'b1);
        run_op(1'b0, 8'hA5, 8'h3C, 1'b1);

        alu_a = 8'h6E; alu_b = 8'h21; alu_sub = 1'b0;
        #1;
        chk("pass_ab2", {add_a, add_b}, 16'h6E21);
        chk("pass_sub2", {15'd0, add_sub}, 16'd0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_op(1'($urandom), ra, rb, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; op = 1'b0; opa = 8'hEE; opb = 8'hDD;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_state", {11'd0, busy, done, div0, 2'b00}, 16'd0);
        chk("midrst_res", {res_hi, res_lo}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b1, 8'hC8, 8'h07, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
